// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction-decode pipeline stage.
//
// Holds the IF/ID pipeline register, the 32x32 register file (one write-back
// port with write-through), the opcode decoder and the ID/EX pipeline register.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   if_instr, if_pc fetched instruction and its PC
//   stall           hold IF/ID, inject a bubble into ID/EX
//   flush           squash IF/ID and ID/EX (branch taken in EXE)
//   wb_en/dest/data register-file write-back port
//   id_src1/2       combinational source indices of the IF/ID instruction
//   id_two_src      combinational: IF/ID instruction reads two registers
//   ex_*            registered control, operands and indices for execute
//   illegal_op      (only with ID_ILLEGAL_DETECT_EN) sticky undefined-opcode flag
//
// Build option: define ID_ILLEGAL_DETECT_EN to add the illegal_op output.
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int          REG_COUNT = 32,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic [4:0]  id_src1,
  output logic [4:0]  id_src2,
  output logic        id_two_src,
  output logic [31:0] ex_pc,
  output logic [3:0]  ex_cmd,
  output logic        ex_mem_r,
  output logic        ex_mem_w,
  output logic        ex_wb_en,
  output logic [1:0]  ex_br_type,
  output logic [31:0] ex_val1,
  output logic [31:0] ex_val2,
  output logic [31:0] ex_st_val,
  output logic [4:0]  ex_dest,
  output logic [4:0]  ex_src1,
  output logic [4:0]  ex_src2
`ifdef ID_ILLEGAL_DETECT_EN
  ,
  output logic        illegal_op
`endif
);

  // IF/ID pipeline register
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  // register file
  logic [31:0] regs_q [REG_COUNT];
  logic [31:0] regs_d [REG_COUNT];

  // ID/EX pipeline register
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [3:0]  ex_cmd_q, ex_cmd_d;
  logic        ex_mem_r_q, ex_mem_r_d;
  logic        ex_mem_w_q, ex_mem_w_d;
  logic        ex_wb_en_q, ex_wb_en_d;
  logic [1:0]  ex_br_type_q, ex_br_type_d;
  logic [31:0] ex_val1_q, ex_val1_d;
  logic [31:0] ex_val2_q, ex_val2_d;
  logic [31:0] ex_st_val_q, ex_st_val_d;
  logic [4:0]  ex_dest_q, ex_dest_d;
  logic [4:0]  ex_src1_q, ex_src1_d;
  logic [4:0]  ex_src2_q, ex_src2_d;

  // decoder outputs
  logic [5:0]  opcode_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [31:0] imm_ext_s;
  logic [3:0]  dec_cmd_s;
  logic        dec_mem_r_s;
  logic        dec_mem_w_s;
  logic        dec_wb_en_s;
  logic [1:0]  dec_br_s;
  logic [4:0]  dec_dest_s;
  logic        dec_rtype_s;
  logic        dec_two_src_s;
  logic        dec_illegal_s;

  // register read values (after write-through)
  logic [31:0] rd_val1_s;
  logic [31:0] rd_val2_s;

  // ID/EX captures only when nothing squashes or holds the stage
  logic        capture_s;

  assign opcode_s  = instr_q[31:26];
  assign rs_s      = instr_q[25:21];
  assign rt_s      = instr_q[20:16];
  assign rd_s      = instr_q[15:11];
  assign imm_ext_s = {{16{instr_q[15]}}, instr_q[15:0]};
  assign capture_s = ~(rst | flush | stall);

  assign id_src1    = rs_s;
  assign id_src2    = rt_s;
  assign id_two_src = dec_two_src_s;

  // IF/ID next state: reset/flush load a NOP, stall holds, otherwise capture
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (rst || flush) begin
      instr_d = NOP_WORD;
      pc_d    = 32'h0000_0000;
    end else if (stall) begin
      instr_d = instr_q;
      pc_d    = pc_q;
    end else begin
      instr_d = if_instr;
      pc_d    = if_pc;
    end
  end

  // IF/ID register
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  // register file next state: clear on reset, r0 writes are dropped
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_d[i] = 32'h0000_0000;
      end
    end else if (wb_en && (wb_dest != 5'd0)) begin
      regs_d[wb_dest] = wb_data;
    end else begin
      regs_d[0] = regs_q[0];
    end
  end

  // register file storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // combinational reads; a same-cycle write-back to the index is forwarded
  always_comb begin
    rd_val1_s = 32'h0000_0000;
    rd_val2_s = 32'h0000_0000;
    if (rs_s == 5'd0) begin
      rd_val1_s = 32'h0000_0000;
    end else if (wb_en && (wb_dest == rs_s)) begin
      rd_val1_s = wb_data;
    end else begin
      rd_val1_s = regs_q[rs_s];
    end
    if (rt_s == 5'd0) begin
      rd_val2_s = 32'h0000_0000;
    end else if (wb_en && (wb_dest == rt_s)) begin
      rd_val2_s = wb_data;
    end else begin
      rd_val2_s = regs_q[rt_s];
    end
  end

  // opcode decoder; unknown opcodes decode as a bubble
  always_comb begin
    dec_cmd_s     = 4'b0000;
    dec_mem_r_s   = 1'b0;
    dec_mem_w_s   = 1'b0;
    dec_wb_en_s   = 1'b0;
    dec_br_s      = 2'b00;
    dec_dest_s    = 5'd0;
    dec_rtype_s   = 1'b0;
    dec_illegal_s = 1'b0;
    case (opcode_s)
      6'b000001: begin dec_cmd_s = 4'b0001; dec_rtype_s = 1'b1; end
      6'b000011: begin dec_cmd_s = 4'b0010; dec_rtype_s = 1'b1; end
      6'b000101: begin dec_cmd_s = 4'b0011; dec_rtype_s = 1'b1; end
      6'b000110: begin dec_cmd_s = 4'b0100; dec_rtype_s = 1'b1; end
      6'b000111: begin dec_cmd_s = 4'b0101; dec_rtype_s = 1'b1; end
      6'b001000: begin dec_cmd_s = 4'b0110; dec_rtype_s = 1'b1; end
      6'b001001: begin dec_cmd_s = 4'b0111; dec_rtype_s = 1'b1; end
      6'b001010: begin dec_cmd_s = 4'b1000; dec_rtype_s = 1'b1; end
      6'b001011: begin dec_cmd_s = 4'b1001; dec_rtype_s = 1'b1; end
      6'b001100: begin dec_cmd_s = 4'b1010; dec_rtype_s = 1'b1; end
      6'b100000: begin dec_cmd_s = 4'b0001; dec_wb_en_s = 1'b1; dec_dest_s = rt_s; end
      6'b100001: begin dec_cmd_s = 4'b0010; dec_wb_en_s = 1'b1; dec_dest_s = rt_s; end
      6'b100100: begin
        dec_cmd_s   = 4'b0001;
        dec_mem_r_s = 1'b1;
        dec_wb_en_s = 1'b1;
        dec_dest_s  = rt_s;
      end
      6'b100101: begin dec_cmd_s = 4'b0001; dec_mem_w_s = 1'b1; end
      6'b101000: begin dec_br_s = 2'b01; end
      6'b101001: begin dec_br_s = 2'b10; end
      6'b101010: begin dec_br_s = 2'b11; end
      6'b000000: begin dec_cmd_s = 4'b0000; end
      default:   begin dec_illegal_s = 1'b1; end
    endcase
    if (dec_rtype_s) begin
      dec_wb_en_s = 1'b1;
      dec_dest_s  = rd_s;
    end else begin
      dec_wb_en_s = dec_wb_en_s;
    end
  end

  // st and bne read [20:16] as a second source alongside R-type
  assign dec_two_src_s = dec_rtype_s | dec_mem_w_s | (dec_br_s == 2'b10);

  // ID/EX next state: bubble (all zero) unless the stage captures
  always_comb begin
    ex_pc_d      = 32'h0000_0000;
    ex_cmd_d     = 4'b0000;
    ex_mem_r_d   = 1'b0;
    ex_mem_w_d   = 1'b0;
    ex_wb_en_d   = 1'b0;
    ex_br_type_d = 2'b00;
    ex_val1_d    = 32'h0000_0000;
    ex_val2_d    = 32'h0000_0000;
    ex_st_val_d  = 32'h0000_0000;
    ex_dest_d    = 5'd0;
    ex_src1_d    = 5'd0;
    ex_src2_d    = 5'd0;
    if (capture_s) begin
      ex_pc_d      = pc_q;
      ex_cmd_d     = dec_cmd_s;
      ex_mem_r_d   = dec_mem_r_s;
      ex_mem_w_d   = dec_mem_w_s;
      ex_wb_en_d   = dec_wb_en_s;
      ex_br_type_d = dec_br_s;
      ex_val1_d    = rd_val1_s;
      ex_val2_d    = dec_rtype_s ? rd_val2_s : imm_ext_s;
      ex_st_val_d  = rd_val2_s;
      ex_dest_d    = dec_dest_s;
      ex_src1_d    = rs_s;
      ex_src2_d    = rt_s;
    end else begin
      ex_pc_d      = 32'h0000_0000;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    ex_pc_q      <= ex_pc_d;
    ex_cmd_q     <= ex_cmd_d;
    ex_mem_r_q   <= ex_mem_r_d;
    ex_mem_w_q   <= ex_mem_w_d;
    ex_wb_en_q   <= ex_wb_en_d;
    ex_br_type_q <= ex_br_type_d;
    ex_val1_q    <= ex_val1_d;
    ex_val2_q    <= ex_val2_d;
    ex_st_val_q  <= ex_st_val_d;
    ex_dest_q    <= ex_dest_d;
    ex_src1_q    <= ex_src1_d;
    ex_src2_q    <= ex_src2_d;
  end

  assign ex_pc      = ex_pc_q;
  assign ex_cmd     = ex_cmd_q;
  assign ex_mem_r   = ex_mem_r_q;
  assign ex_mem_w   = ex_mem_w_q;
  assign ex_wb_en   = ex_wb_en_q;
  assign ex_br_type = ex_br_type_q;
  assign ex_val1    = ex_val1_q;
  assign ex_val2    = ex_val2_q;
  assign ex_st_val  = ex_st_val_q;
  assign ex_dest    = ex_dest_q;
  assign ex_src1    = ex_src1_q;
  assign ex_src2    = ex_src2_q;

`ifdef ID_ILLEGAL_DETECT_EN
  logic illegal_q, illegal_d;

  // sticky flag: set when an undefined opcode would be issued
  always_comb begin
    illegal_d = illegal_q;
    if (rst) begin
      illegal_d = 1'b0;
    end else if (capture_s && dec_illegal_s) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // illegal-opcode flag register
  always_ff @(posedge clk) begin
    illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  logic unused_illegal_s;
  assign unused_illegal_s = dec_illegal_s;
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, wb_en;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_dest;
  logic [4:0]  id_src1, id_src2;
  logic        id_two_src;
  logic [31:0] ex_pc, ex_val1, ex_val2, ex_st_val;
  logic [3:0]  ex_cmd;
  logic        ex_mem_r, ex_mem_w, ex_wb_en;
  logic [1:0]  ex_br_type;
  logic [4:0]  ex_dest, ex_src1, ex_src2;
`ifdef ID_ILLEGAL_DETECT_EN
  logic        illegal_op;
  logic        m_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_pc(ex_pc), .ex_cmd(ex_cmd), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_wb_en(ex_wb_en), .ex_br_type(ex_br_type), .ex_val1(ex_val1), .ex_val2(ex_val2),
    .ex_st_val(ex_st_val), .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
`ifdef ID_ILLEGAL_DETECT_EN
    , .illegal_op(illegal_op)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mr, mw, wb;
    logic [1:0]  br;
    logic [31:0] v1, v2, st;
    logic [4:0]  dest, s1, s2;
  } ex_t;

  ex_t obs;
  assign obs = {ex_pc, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_br_type,
                ex_val1, ex_val2, ex_st_val, ex_dest, ex_src1, ex_src2};

  // reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc;
  ex_t         m_ex;

  // R-type opcodes listed in ALU-command order: cmd = position + 1
  logic [5:0] r_ops [10] = '{6'h01, 6'h03, 6'h05, 6'h06, 6'h07,
                             6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C};
  logic [5:0] valid_ops [17] = '{6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h20, 6'h21, 6'h24, 6'h25,
                                 6'h28, 6'h29, 6'h2A};

  function automatic int r_index(input logic [5:0] op);
    for (int i = 0; i < 10; i++) if (r_ops[i] == op) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wd, input logic [31:0] wv);
    if (idx == 5'd0) return 32'h0;
    if (we && wd == idx) return wv;
    return m_regs[idx];
  endfunction

  function automatic logic m_two_src(input logic [31:0] ins);
    return (r_index(ins[31:26]) >= 0) || ins[31:26] == 6'h25 || ins[31:26] == 6'h29;
  endfunction

  // one clock: drive inputs, advance the model, then land 1 time unit after the edge
  task automatic step(input logic r, input logic f, input logic s, input logic [31:0] ins,
                      input logic [31:0] pc, input logic we, input logic [4:0] wd,
                      input logic [31:0] wv);
    ex_t nx;
    logic [5:0] op;
    int ri;
    rst = r; flush = f; stall = s; if_instr = ins; if_pc = pc;
    wb_en = we; wb_dest = wd; wb_data = wv;
    nx = '0;
    op = m_instr[31:26];
    ri = r_index(op);
    if (!r && !f && !s) begin
      nx.pc = m_pc;
      nx.s1 = m_instr[25:21];
      nx.s2 = m_instr[20:16];
      nx.v1 = m_read(m_instr[25:21], we, wd, wv);
      nx.st = m_read(m_instr[20:16], we, wd, wv);
      nx.v2 = (ri >= 0) ? nx.st : {{16{m_instr[15]}}, m_instr[15:0]};
      if (ri >= 0) begin
        nx.cmd = 4'(ri + 1); nx.wb = 1'b1; nx.dest = m_instr[15:11];
      end else if (op == 6'h20 || op == 6'h21) begin
        nx.cmd = (op == 6'h20) ? 4'd1 : 4'd2; nx.wb = 1'b1; nx.dest = m_instr[20:16];
      end else if (op == 6'h24) begin
        nx.cmd = 4'd1; nx.mr = 1'b1; nx.wb = 1'b1; nx.dest = m_instr[20:16];
      end else if (op == 6'h25) begin
        nx.cmd = 4'd1; nx.mw = 1'b1;
      end else if (op >= 6'h28 && op <= 6'h2A) begin
        nx.br = 2'(op - 6'h27);
      end
`ifdef ID_ILLEGAL_DETECT_EN
      if (op != 6'h00 && nx.cmd == 4'd0 && nx.br == 2'd0) m_illegal = 1'b1;
`endif
    end
    @(posedge clk);
    m_ex = nx;
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
`ifdef ID_ILLEGAL_DETECT_EN
      m_illegal = 1'b0;
`endif
    end else if (we && wd != 5'd0) begin
      m_regs[wd] = wv;
    end
    if (r || f) begin
      m_instr = 32'h0; m_pc = 32'h0;
    end else if (!s) begin
      m_instr = ins; m_pc = pc;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h8022_0005, 32'h40, 1'b0, 5'd0, 32'h0);
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_ex: got %h want 0", obs); end
    checks++; if (id_src1 !== 5'd0) begin errors++; $display("FAIL reset_src1: got %0d want 0", id_src1); end
    checks++; if (id_two_src !== 1'b0) begin errors++; $display("FAIL reset_two_src: got %0b want 0", id_two_src); end
  endtask

  task automatic test_rtype();
    step(1'b0, 1'b0, 1'b0, 32'h0401_1000, 32'h100, 1'b0, 5'd0, 32'h0);
    checks++; if (id_two_src !== 1'b1) begin errors++; $display("FAIL add_two_src: got %0b want 1", id_two_src); end
    // r1 written in the same cycle the add reads it
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h104, 1'b1, 5'd1, 32'd1546);
    checks++;
    if (ex_cmd !== 4'b0001 || ex_wb_en !== 1'b1 || ex_dest !== 5'd2 || ex_val1 !== 32'd0 ||
        ex_val2 !== 32'd1546 || ex_pc !== 32'h100) begin
      errors++; $display("FAIL add_decode: got cmd=%h wb=%b dest=%0d v1=%0d v2=%0d pc=%h want 1 1 2 0 1546 100",
                         ex_cmd, ex_wb_en, ex_dest, ex_val1, ex_val2, ex_pc);
    end
    checks++; if (obs !== m_ex) begin errors++; $display("FAIL add_model: got %h want %h", obs, m_ex); end
  endtask

  task automatic test_imm();
    step(1'b0, 1'b0, 1'b0, 32'h8465_8000, 32'h108, 1'b0, 5'd0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h10C, 1'b0, 5'd0, 32'h0);
    checks++;
    if (ex_val2 !== 32'hFFFF_8000 || ex_cmd !== 4'b0010 || ex_dest !== 5'd5 || ex_wb_en !== 1'b1) begin
      errors++; $display("FAIL subi_sext: got v2=%h cmd=%h dest=%0d wb=%b want ffff8000 2 5 1",
                         ex_val2, ex_cmd, ex_dest, ex_wb_en);
    end
  endtask

  task automatic test_mem();
    step(1'b0, 1'b0, 1'b0, 32'h9422_0014, 32'h110, 1'b1, 5'd2, 32'h0000_1234);
    step(1'b0, 1'b0, 1'b0, 32'h9024_0008, 32'h114, 1'b0, 5'd0, 32'h0);
    checks++;
    if (ex_mem_w !== 1'b1 || ex_wb_en !== 1'b0 || ex_st_val !== 32'h1234 || ex_val2 !== 32'd20 ||
        ex_mem_r !== 1'b0) begin
      errors++; $display("FAIL store: got mw=%b wb=%b st=%h v2=%0d mr=%b want 1 0 1234 20 0",
                         ex_mem_w, ex_wb_en, ex_st_val, ex_val2, ex_mem_r);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h118, 1'b0, 5'd0, 32'h0);
    checks++;
    if (ex_mem_r !== 1'b1 || ex_wb_en !== 1'b1 || ex_dest !== 5'd4 || ex_val1 !== 32'd1546) begin
      errors++; $display("FAIL load: got mr=%b wb=%b dest=%0d v1=%0d want 1 1 4 1546",
                         ex_mem_r, ex_wb_en, ex_dest, ex_val1);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b0, 1'b0, 32'h1822_3800, 32'h200, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      // r2 updated mid-stall must be seen when the or finally issues
      step(1'b0, 1'b0, 1'b1, 32'h0401_1000, 32'h204, (i == 1), 5'd2, 32'd77);
      checks++;
      if (obs !== '0 || id_src1 !== 5'd1 || id_src2 !== 5'd2) begin
        errors++; $display("FAIL stall_bubble%0d: got ex=%h src1=%0d src2=%0d want 0 1 2", i, obs, id_src1, id_src2);
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h208, 1'b0, 5'd0, 32'h0);
    checks++;
    if (ex_cmd !== 4'b0100 || ex_dest !== 5'd7 || ex_val1 !== 32'd1546 || ex_val2 !== 32'd77 ||
        ex_pc !== 32'h200) begin
      errors++; $display("FAIL stall_release: got cmd=%h dest=%0d v1=%0d v2=%0d pc=%h want 4 7 1546 77 200",
                         ex_cmd, ex_dest, ex_val1, ex_val2, ex_pc);
    end
  endtask

  task automatic test_flush_r0();
    step(1'b0, 1'b0, 1'b0, 32'h1822_3800, 32'h300, 1'b0, 5'd0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0401_1000, 32'h304, 1'b0, 5'd0, 32'h0);
    checks++;
    if (obs !== '0 || id_src1 !== 5'd0 || id_two_src !== 1'b0) begin
      errors++; $display("FAIL flush: got ex=%h src1=%0d two=%b want 0 0 0", obs, id_src1, id_two_src);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0400_1800, 32'h308, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h30C, 1'b1, 5'd0, 32'hDEAD_BEEF);
    checks++;
    if (ex_val1 !== 32'd0 || ex_val2 !== 32'd0 || ex_dest !== 5'd3) begin
      errors++; $display("FAIL r0_write: got v1=%h v2=%h dest=%0d want 0 0 3", ex_val1, ex_val2, ex_dest);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0]  op;
    for (int n = 0; n < 400; n++) begin
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : valid_ops[$urandom_range(0, 16)];
      ins = {op, 26'($urandom)};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ins, $urandom, ($urandom_range(0, 1) == 1), 5'($urandom), $urandom);
      checks++;
      if (obs !== m_ex) begin errors++; $display("FAIL rand_ex[%0d]: got %h want %h", n, obs, m_ex); end
      checks++;
      if (id_src1 !== m_instr[25:21] || id_src2 !== m_instr[20:16] || id_two_src !== m_two_src(m_instr)) begin
        errors++; $display("FAIL rand_id[%0d]: got %0d %0d %b want %0d %0d %b", n, id_src1, id_src2,
                           id_two_src, m_instr[25:21], m_instr[20:16], m_two_src(m_instr));
      end
`ifdef ID_ILLEGAL_DETECT_EN
      checks++;
      if (illegal_op !== m_illegal) begin errors++; $display("FAIL rand_illegal[%0d]: got %b want %b", n, illegal_op, m_illegal); end
`endif
    end
  endtask

  initial begin
    m_instr = 32'h0; m_pc = 32'h0; m_ex = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
`ifdef ID_ILLEGAL_DETECT_EN
    m_illegal = 1'b0;
`endif
    rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_en = 1'b0;
    wb_dest = 5'd0; wb_data = 32'h0; if_instr = 32'h0; if_pc = 32'h0;
    test_reset();
    test_rtype();
    test_imm();
    test_mem();
    test_stall();
    test_flush_r0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
